serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Bit-serial adder/subtractor for the MyALU lab datapath. It instantiates exactly one of the team's 1-bit full-adder cells (inputs a, b, ci; outputs s, c0). Each clock it feeds the cell one operand bit pair, LSB first, and registers the carry between cycles. It trades WIDTH cycles of latency for a single adder cell and exposes a start/busy/done handshake to the ALU control.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request operation; sampled only in IDLE
sub  input  1  0 = A+B, 1 = A-B; captured with start
a  input  WIDTH  operand A, captured with start
b  input  WIDTH  operand B, captured with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/flags valid
result  output  WIDTH  sum/difference, held until next accepted start
cout  output  1  final carry out (sub: 1 = no borrow)
overflow  output  1  signed overflow

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (rst_n). Asserting rst_n=0 at any time, including mid-RUN, forces:
  - state = IDLE;
  - busy, done, result, cout, overflow = 0;
  - internal shift registers, carry and bit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, capture a into shift reg SA.
  - Capture b into shift reg SB; if sub=1, capture ~b instead.
  - Set carry register C = sub; clear bit counter; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge, the cell computes s, c0 from SA[0], SB[0], C.
  - s shifts into the result register MSB-side (the result shifts right), so after WIDTH edges bit i sits at position i.
  - C <= c0; SA and SB shift right by one; counter increments.
  - At the edge that processes bit WIDTH-1: register c_msb_in = C (carry into the MSB) and final c0.
  - That edge moves the FSM to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
- Outputs during DONE:
  - cout = final c0;
  - overflow = c_msb_in XOR final c0;
  - result = full WIDTH-bit value.
- Latency: start accepted at edge k; bits processed at edges k+1..k+WIDTH; done high in the cycle following edge k+WIDTH. result/cout/overflow are stable from then until the next accepted start.
- Handshake:
  - start while busy or in DONE is ignored; no queuing.
  - start held high continuously is re-accepted in IDLE immediately after DONE. Back-to-back throughput is one operation per WIDTH+2 cycles.
  - a, b and sub may change freely after capture without affecting the operation in flight.
- result is not updated bit-by-bit visibly. The internal accumulator copies to result at the DONE transition; result shows the previous value during RUN.
- Arithmetic is modulo 2^WIDTH. Operands are interpreted as two's complement for overflow only.
- Counter width: $clog2(WIDTH)+1; it must not wrap before WIDTH bits have been processed.

Test Plan:
- 100+27, sub=0 (0x64+0x1B), WIDTH=8 -> done exactly 8 cycles after the start edge. Expect result=0x7F, cout=0, overflow=0; busy high for 8 cycles.
- 100+100 (0x64+0x64) -> result=0xC8, cout=0, overflow=1.
- 0xFF+0x01, sub=0 -> result=0x00, cout=1, overflow=0.
- Subtraction:
  - 0x05-0x07 -> result=0xFE, cout=0, overflow=0;
  - 0x80-0x01 -> result=0x7F, cout=1, overflow=1.
- Busy/hold behaviour: pulse start with 0x10+0x20, then change a/b/sub and pulse start again during RUN -> second start ignored; result=0x30. Holding start high through DONE -> new op begins the cycle after done.
- Reset mid-run: assert rst_n=0 at bit 4 of a RUN -> all outputs 0 immediately (asynchronous). After release, a fresh 0x0F+0x01 -> result=0x10, with no stale carry.

Source files
------------

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c0
);

  assign s  = a ^ b ^ ci;
  assign c0 = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor built around one full-adder cell
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  // One extra bit so the counter can never wrap while bits remain.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic             c_msb_in;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c0;
  logic             last_bit;

  // The single adder cell sees the current LSBs and the registered carry.
  full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (c),
    .s  (fa_s),
    .c0 (fa_c0)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign overflow = c_msb_in ^ cout;

  // Control FSM plus the serial datapath; outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      acc      <= '0;
      c        <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            sb    <= sub ? ~b : b;
            c     <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= {fa_s, acc[WIDTH-1:1]};
          c   <= fa_c0;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            // Publish the finished word and flags only now; result stays
            // at its old value for the whole run.
            result   <= {fa_s, acc[WIDTH-1:1]};
            cout     <= fa_c0;
            c_msb_in <= c;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_cmp;
  int n_bad;
  logic [W-1:0] prev_result;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] er;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the two's-complement operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       output logic [W-1:0] r, output logic co, output logic ov);
    int sa_i;
    int sb_i;
    int sres;
    logic [W:0] wide;
    sa_i = int'($signed(ma));
    sb_i = int'($signed(mb));
    if (msub) begin
      wide = {1'b0, ma} + {1'b0, ~mb} + 1;
      sres = sa_i - sb_i;
    end else begin
      wide = {1'b0, ma} + {1'b0, mb};
      sres = sa_i + sb_i;
    end
    r  = wide[W-1:0];
    co = wide[W];
    ov = (sres > 127) || (sres < -128);
  endtask

  // Pulse start for one edge, then wait (bounded) for done and check everything.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input logic [W-1:0] er, input logic ec, input logic eo);
    int n;
    int nbusy;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ~tb_; sub = ~ts;
    n = 0;
    nbusy = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (busy && !done) nbusy++;
      if (n == 4) check({tag, " result held in RUN"}, result, prev_result);
    end
    check({tag, " latency"}, n, W);
    check({tag, " busy cycles"}, nbusy, W);
    check({tag, " result"}, result, er);
    check({tag, " cout"}, cout, ec);
    check({tag, " overflow"}, overflow, eo);
    prev_result = er;
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " result stable"}, result, er);
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic         rs, ec, eo;
    int n;

    n_cmp = 0;
    n_bad = 0;
    prev_result = '0;
    rst_n = 1'b0;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{8'h64, 8'h1B, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 8'h00);
    check("reset cout", cout, 1'b0);
    check("reset overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
             vecs[i].er, vecs[i].ec, vecs[i].eo);

    // Start during RUN must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h55; b = 8'h11; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("ignore start result", result, 8'h30);
    check("ignore start done seen", done, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("ignore start not queued", busy, 1'b0);
    prev_result = 8'h30;

    // Held start is re-accepted the edge right after the DONE cycle.
    @(negedge clk);
    a = 8'h21; b = 8'h03; sub = 1'b0; start = 1'b1;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("hold first result", result, 8'h24);
    @(negedge clk);
    check("hold idle gap busy", busy, 1'b0);
    @(negedge clk);
    check("hold re-accept busy", busy, 1'b1);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("hold second done", done, 1'b1);
    check("hold second result", result, 8'h24);
    @(negedge clk);
    prev_result = 8'h24;

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 1'b0);
    check("async rst done", done, 1'b0);
    check("async rst result", result, 8'h00);
    check("async rst cout", cout, 1'b0);
    check("async rst overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_result = '0;
    run_op("post reset", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, er, ec, eo);
      run_op($sformatf("rand%0d", i), ra, rb, rs, er, ec, eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
